// File: rtl/wb_core_pkg.sv
// Shared sizing, FSM state type and decoded-request record for the
// Wishbone register slave.
package wb_core_pkg;

    localparam int ADDR_WIDTH   = 16;
    localparam int DATA_WIDTH   = 32;
    localparam int GRANULE      = 8;
    localparam int REGISTER_NUM = 16;
    localparam int SEL_WIDTH    = DATA_WIDTH / GRANULE;
    localparam int IDX_WIDTH    = $clog2(REGISTER_NUM);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [IDX_WIDTH-1:0]  idx;
        logic [SEL_WIDTH-1:0]  sel;
        logic [DATA_WIDTH-1:0] dat;
        logic                  err;
    } req_t;

endpackage

// File: rtl/wb_reg_bank.sv
// Register array with per-lane write enables and an asynchronous read port.
// Every word clears on reset.
module wb_reg_bank #(
    parameter int DATA_WIDTH   = 32,
    parameter int GRANULE      = 8,
    parameter int REGISTER_NUM = 16,
    localparam int SEL_WIDTH   = DATA_WIDTH / GRANULE,
    localparam int IDX_WIDTH   = $clog2(REGISTER_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] regs [REGISTER_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGISTER_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < SEL_WIDTH; k++) begin
                if (sel[k]) begin
                    regs[idx][k*GRANULE +: GRANULE] <= wdata[k*GRANULE +: GRANULE];
                end
            end
        end
    end

    assign rdata = regs[idx];

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone B4 pipelined slave fronting a small control register file.
// One request outstanding; optional wait states; bad accesses end with err_o.
//
//   state | meaning
//   IDLE  | no request outstanding, ready to accept
//   WAIT  | request accepted, counting wait states, stall_o high
//   RESP  | ack_o/err_o pulse; a new request may be accepted this cycle
module wb_reg_slave #(
    parameter int  ADDR_WIDTH   = wb_core_pkg::ADDR_WIDTH,
    parameter int  DATA_WIDTH   = wb_core_pkg::DATA_WIDTH,
    parameter int  GRANULE      = wb_core_pkg::GRANULE,
    parameter int  REGISTER_NUM = wb_core_pkg::REGISTER_NUM,
    parameter int  WAIT_STATES  = 0,
    localparam int SEL_WIDTH    = DATA_WIDTH / GRANULE,
    localparam int AW_LSB       = $clog2(SEL_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  stall_o
);

    import wb_core_pkg::*;

    localparam int WORD_WIDTH = ADDR_WIDTH - AW_LSB;
    localparam int BANK_IDX_W = $clog2(REGISTER_NUM);
    localparam int CNT_WIDTH  = 3;
    localparam logic [CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? CNT_WIDTH'(WAIT_STATES - 1) : '0;

    state_e                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   wait_cnt, wait_cnt_nxt;
    logic                   resp_err;
    logic [DATA_WIDTH-1:0]  resp_dat;
    logic [DATA_WIDTH-1:0]  bank_rdata;
    logic [WORD_WIDTH-1:0]  word;
    logic                   accept;
    logic                   bank_wr;
    req_t                   req;

    assign word    = adr_i[ADDR_WIDTH-1:AW_LSB];
    assign stall_o = (state == WAIT);
    assign accept  = cyc_i & stb_i & ~stall_o;

    always_comb begin
        req.we  = we_i;
        req.idx = word[BANK_IDX_W-1:0];
        req.sel = sel_i;
        req.dat = dat_i;
        req.err = (|adr_i[AW_LSB-1:0])
               || (word >= WORD_WIDTH'(REGISTER_NUM))
               || (sel_i == '0);
    end

    // Writes land on the accept edge, so an abort later cannot undo them.
    assign bank_wr = accept & req.we & ~req.err;

    wb_reg_bank #(
        .DATA_WIDTH   (DATA_WIDTH),
        .GRANULE      (GRANULE),
        .REGISTER_NUM (REGISTER_NUM)
    ) u_bank (
        .clk   (clk_i),
        .rst_n (rst_i),
        .wr_en (bank_wr),
        .idx   (req.idx),
        .sel   (req.sel),
        .wdata (req.dat),
        .rdata (bank_rdata)
    );

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        state_nxt = RESP;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (!cyc_i) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
            resp_err <= 1'b0;
            resp_dat <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                resp_err <= req.err;
                resp_dat <= req.err ? '0 : bank_rdata;
            end
        end
    end

    // Termination is gated by cyc_i so a master dropping the cycle never sees it.
    assign ack_o = (state == RESP) & cyc_i & ~resp_err;
    assign err_o = (state == RESP) & cyc_i & resp_err;
    assign dat_o = ack_o ? resp_dat : '0;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Bench for wb_reg_slave: two instances (0 and 3 wait states) share one bus
// and are compared every cycle against a transaction-level model.
module tb_wb_reg_slave;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [15:0] adr   = '0;
    logic [3:0]  sel   = '0;
    logic [31:0] dat   = '0;

    logic [31:0] dat0, dat3;
    logic        ack0, err0, stall0;
    logic        ack3, err3, stall3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_reg_slave #(.WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .sel_i(sel), .dat_i(dat),
        .dat_o(dat0), .ack_o(ack0), .err_o(err0), .stall_o(stall0)
    );

    wb_reg_slave #(.WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .sel_i(sel), .dat_i(dat),
        .dat_o(dat3), .ack_o(ack3), .err_o(err3), .stall_o(stall3)
    );

    // Model: per instance, the word array plus one pending response that
    // becomes visible after 'rem' stalled cycles.
    bit [31:0] mem  [2][16];
    bit        pend [2];
    int        rem  [2];
    bit        perr [2];
    bit [31:0] pdat [2];
    int        ws   [2] = '{0, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0;
            rem[d]  = 0;
            perr[d] = 1'b0;
            pdat[d] = '0;
            for (int i = 0; i < 16; i++) mem[d][i] = '0;
        end
    endfunction

    function automatic void model_step(input int d);
        bit busy, acc, e;
        int w;
        busy = pend[d] && (rem[d] > 0);
        acc  = (cyc === 1'b1) && (stb === 1'b1) && !busy;
        if (pend[d]) begin
            if (cyc !== 1'b1)   pend[d] = 1'b0;
            else if (rem[d] > 0) rem[d] = rem[d] - 1;
            else                 pend[d] = 1'b0;
        end
        if (acc) begin
            w = int'(adr) / 4;
            e = (adr[1:0] != 2'b00) || (w >= 16) || (sel == 4'h0);
            perr[d] = e;
            pdat[d] = '0;
            if (!e) begin
                pdat[d] = mem[d][w];
                if (we === 1'b1) begin
                    for (int k = 0; k < 4; k++) begin
                        if (sel[k]) mem[d][w][8*k +: 8] = dat[8*k +: 8];
                    end
                end
            end
            pend[d] = 1'b1;
            rem[d]  = ws[d];
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic check_dut(input int d, input logic a, input logic e,
                             input logic s, input logic [31:0] dt);
        bit resp, x_ack, x_err, x_stall;
        x_stall = pend[d] && (rem[d] > 0);
        resp    = pend[d] && (rem[d] == 0) && (cyc === 1'b1);
        x_ack   = resp && !perr[d];
        x_err   = resp && perr[d];
        checkb($sformatf("ack_ws%0d", ws[d]), a, x_ack);
        checkb($sformatf("err_ws%0d", ws[d]), e, x_err);
        checkb($sformatf("stall_ws%0d", ws[d]), s, x_stall);
        check($sformatf("dat_ws%0d", ws[d]), dt, x_ack ? pdat[d] : 32'h0);
    endtask

    always @(negedge clk) begin
        check_dut(0, ack0, err0, stall0, dat0);
        check_dut(1, ack3, err3, stall3, dat3);
    end

    // One request on both instances, then idle with cyc held until both answer.
    task automatic xfer(input bit w, input logic [15:0] a, input logic [3:0] s, input logic [31:0] d,
                        output int l0, output logic [31:0] r0, output bit e0,
                        output int l3, output logic [31:0] r3, output bit e3);
        l0 = -1; l3 = -1; r0 = '0; r3 = '0; e0 = 1'b0; e3 = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        @(posedge clk); #2;
        stb = 1'b0; we = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if ((ack0 || err0) && l0 < 0) begin l0 = n; r0 = dat0; e0 = err0; end
            if ((ack3 || err3) && l3 < 0) begin l3 = n; r3 = dat3; e3 = err3; end
            @(posedge clk); #2;
        end
        cyc = 1'b0;
    endtask

    initial begin
        int          l0, l3, acks, resp3;
        logic [31:0] r0, r3, d8;
        bit          e0, e3, stalled;
        logic [31:0] bdat [4];
        logic [7:0]  spat, apat;

        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        @(posedge clk); #2;

        // Fresh registers read as zero; latency 1 and 4.
        xfer(1'b0, 16'h000C, 4'hF, 32'h0, l0, r0, e0, l3, r3, e3);
        check("rst_read_lat0", l0, 1);
        check("rst_read_dat0", r0, 32'h0);
        checkb("rst_read_err0", e0, 1'b0);
        check("rst_read_lat3", l3, 4);
        check("rst_read_dat3", r3, 32'h0);

        // Partial lane write.
        xfer(1'b1, 16'h0008, 4'hF, 32'hDEADBEEF, l0, r0, e0, l3, r3, e3);
        xfer(1'b1, 16'h0008, 4'b0010, 32'h0000_1200, l0, r0, e0, l3, r3, e3);
        xfer(1'b0, 16'h0008, 4'hF, 32'h0, l0, r0, e0, l3, r3, e3);
        check("lane_dat0", r0, 32'hDEAD12EF);
        check("lane_dat3", r3, 32'hDEAD12EF);

        // Error terminations leave idx 0 intact.
        xfer(1'b1, 16'h0000, 4'hF, 32'h11223344, l0, r0, e0, l3, r3, e3);
        xfer(1'b1, 16'h0041, 4'hF, 32'hFFFFFFFF, l0, r0, e0, l3, r3, e3);
        checkb("err_misalign0", e0, 1'b1);
        checkb("err_misalign3", e3, 1'b1);
        check("err_misalign_lat0", l0, 1);
        xfer(1'b1, 16'h0040, 4'hF, 32'hFFFFFFFF, l0, r0, e0, l3, r3, e3);
        checkb("err_range0", e0, 1'b1);
        check("err_range_lat3", l3, 4);
        xfer(1'b1, 16'h0000, 4'h0, 32'hFFFFFFFF, l0, r0, e0, l3, r3, e3);
        checkb("err_nosel0", e0, 1'b1);
        xfer(1'b0, 16'h0000, 4'hF, 32'h0, l0, r0, e0, l3, r3, e3);
        check("err_keep0", r0, 32'h11223344);
        check("err_keep3", r3, 32'h11223344);

        // Back-to-back writes on the zero-wait instance.
        acks = 0; stalled = 1'b0;
        cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bdat[i] = $urandom;
            stb = 1'b1; we = 1'b1; adr = 16'(i * 4); sel = 4'hF; dat = bdat[i];
            @(negedge clk);
            if (stall0) stalled = 1'b1;
            if (ack0) acks++;
            @(posedge clk); #2;
        end
        stb = 1'b0; we = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (ack0) acks++;
            @(posedge clk); #2;
        end
        cyc = 1'b0;
        checkb("b2b_stall0", stalled, 1'b0);
        check("b2b_acks0", acks, 4);
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 16'(i * 4), 4'hF, 32'h0, l0, r0, e0, l3, r3, e3);
            check($sformatf("b2b_readback%0d", i), r0, bdat[i]);
        end

        // Wait-state pattern with the strobe held through the stall.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0008; sel = 4'hF;
        @(posedge clk); #2;
        spat = '0; apat = '0; d8 = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            spat[n-1] = stall3;
            apat[n-1] = ack3;
            if (n == 8) d8 = dat3;
            @(posedge clk); #2;
            if (n == 4) stb = 1'b0;
        end
        cyc = 1'b0;
        check("ws3_stall_pattern", 32'(spat), 32'h77);
        check("ws3_ack_pattern", 32'(apat), 32'h88);
        check("ws3_second_dat", d8, 32'hDEAD12EF);

        // Abort during wait states; the write still lands.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0014; sel = 4'hF; dat = 32'h5A5A5A5A;
        @(posedge clk); #2;
        stb = 1'b0; we = 1'b0;
        @(posedge clk); #2;
        cyc = 1'b0;
        resp3 = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (ack3 || err3) resp3++;
            @(posedge clk); #2;
        end
        check("abort_resp3", resp3, 0);
        xfer(1'b0, 16'h0014, 4'hF, 32'h0, l0, r0, e0, l3, r3, e3);
        check("abort_keep3", r3, 32'h5A5A5A5A);
        check("abort_keep0", r0, 32'h5A5A5A5A);

        // Asynchronous reset in the middle of a transaction.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0014; sel = 4'hF;
        @(posedge clk); #3;
        checkb("pre_rst_ack0", ack0, 1'b1);
        checkb("pre_rst_stall3", stall3, 1'b1);
        rst_n = 1'b0;
        #1;
        checkb("rst_ack0", ack0, 1'b0);
        check("rst_dat0", dat0, 32'h0);
        checkb("rst_stall3", stall3, 1'b0);
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        xfer(1'b0, 16'h0014, 4'hF, 32'h0, l0, r0, e0, l3, r3, e3);
        check("post_rst_dat0", r0, 32'h0);
        check("post_rst_dat3", r3, 32'h0);
        check("post_rst_lat0", l0, 1);

        // Random traffic, including protocol-violating patterns and rare resets.
        for (int c = 0; c < 3000; c++) begin
            int idx;
            idx = $urandom_range(0, 17);
            cyc = ($urandom_range(0, 9) != 0);
            stb = ($urandom_range(0, 9) < 7);
            we  = 1'($urandom_range(0, 1));
            adr = 16'(idx * 4 + (($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0));
            sel = 4'($urandom);
            dat = $urandom;
            if ($urandom_range(0, 599) == 0) begin
                #1 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            @(posedge clk); #2;
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (3) begin @(posedge clk); #2; end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
